// File: rtl/pulse_stretch_mc_if.sv
`default_nettype none
// ============================================================================
// Module : pulse_stretch_mc_if
// Brief  : Trigger/stretch-control/status bundle for pulse_stretch_mc.
// Rev    : 1.0 - initial release
// ============================================================================
interface pulse_stretch_mc_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic [CHANNELS-1:0] pulse_in;
  logic [CNT_W-1:0]    stretch_len;
  logic                retrig;
  logic [CHANNELS-1:0] sig_out;
  logic [CHANNELS-1:0] miss;
  logic                busy;

  modport master (
    output pulse_in, stretch_len, retrig,
    input  sig_out, miss, busy
  );

  modport slave (
    input  pulse_in, stretch_len, retrig,
    output sig_out, miss, busy
  );
endinterface
`default_nettype wire

// File: rtl/pulse_stretch_mc.sv
`default_nettype none
// ============================================================================
// Module : pulse_stretch_mc
// Brief  : Multi-lane, counter-based, retriggerable/one-shot pulse stretcher.
// Config : define PULSE_STRETCH_SYNC_EN to add a 2-flop input synchroniser.
// Rev    : 1.0 - initial release
// ============================================================================
module pulse_stretch_mc #(
  parameter int    CHANNELS = 4,
  parameter int    CNT_W    = 8,
  parameter string POLARITY = "HIGH"
) (
  input wire                clk,
  input wire                rst_n,
  pulse_stretch_mc_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_STRETCH = 1'b1
  } state_t;

  localparam logic c_ACT_LOW = (POLARITY == "LOW");

  logic [CHANNELS-1:0] w_pin;
  logic [CHANNELS-1:0] w_act;
  logic [CHANNELS-1:0] w_edge;
  logic [CHANNELS-1:0] r_act_d;
  logic [CHANNELS-1:0] w_stretch_nxt;
  logic [CHANNELS-1:0] w_miss_nxt;
  logic [CHANNELS-1:0] r_sig_out;
  logic [CHANNELS-1:0] r_miss;
  logic                r_busy;

`ifdef PULSE_STRETCH_SYNC_EN
  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= {CHANNELS{c_ACT_LOW}};
      r_sync2 <= {CHANNELS{c_ACT_LOW}};
    end else begin
      r_sync1 <= bus.pulse_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pin = r_sync2;
`else
  assign w_pin = bus.pulse_in;
`endif

  // Normalise to active-high so the lane logic is polarity-agnostic
  assign w_act  = w_pin ^ {CHANNELS{c_ACT_LOW}};
  assign w_edge = w_act & ~r_act_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_act_d <= '0;
    end else begin
      r_act_d <= w_act;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      state_t           r_state;
      state_t           w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             w_miss_l;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
        end
      end

      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_miss_l    = 1'b0;
        case (r_state)
          S_IDLE: begin
            if (w_edge[gi]) begin
              w_state_nxt = S_STRETCH;
              w_cnt_nxt   = bus.stretch_len;
            end
          end
          S_STRETCH: begin
            if (w_edge[gi] && bus.retrig) begin
              w_cnt_nxt = bus.stretch_len;
            end else begin
              // One-shot: the edge is flagged but the countdown proceeds
              w_miss_l = w_edge[gi];
              if (r_cnt == '0) begin
                w_state_nxt = S_IDLE;
              end else begin
                w_cnt_nxt = r_cnt - 1'b1;
              end
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
          end
        endcase
      end

      assign w_stretch_nxt[gi] = (w_state_nxt == S_STRETCH);
      assign w_miss_nxt[gi]    = w_miss_l;
    end
  endgenerate

  // Outputs follow the next-state so they line up with the lane state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig_out <= {CHANNELS{c_ACT_LOW}};
      r_miss    <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_sig_out <= w_stretch_nxt ^ {CHANNELS{c_ACT_LOW}};
      r_miss    <= w_miss_nxt;
      r_busy    <= |w_stretch_nxt;
    end
  end

  assign bus.sig_out = r_sig_out;
  assign bus.miss    = r_miss;
  assign bus.busy    = r_busy;

endmodule
`default_nettype wire
